instr_prefetch_unit: RTL and testbench
======================================

// Module: instr_prefetch_unit
// PURPOSE
//  Upstream fetch stage for the 8-bit bus processor. Walks a program counter through
//  the 32x8 synchronous instruction ROM and buffers fetched words in a small prefetch FIFO.
//  Hands words to the processor DIN path with a valid/ready handshake.
//  Supports a redirect (jump) that flushes all buffered and in-flight words.
// PARAMETERS
//  AW     5  ROM address width; PC range 0..2**AW-1
//  DW     8  instruction/data word width
//  DEPTH  4  prefetch FIFO entries (power of 2, >=2)
// PORTS
//  M_clock        in   1       fetch clock; all state updates on posedge
//  resetn         in   1       reset: synchronous, active-low, clock M_clock
//  rom_addr       out  AW      ROM address; equals pc register (combinational from pc)
//  rom_rden       out  1       ROM read strobe; high in cycles where a fetch issues
//  rom_q          in   DW      ROM data; valid the cycle after the edge that sampled rom_addr
//  redirect       in   1       load new PC, flush FIFO and in-flight read
//  redirect_addr  in   AW      target PC for redirect
//  out_data       out  DW      FIFO head word (to processor DIN)
//  out_addr       out  AW      ROM address the head word came from
//  out_valid      out  1       FIFO non-empty
//  out_ready      in   1       consumer accepts head word this cycle
//  fifo_count     out  3       number of buffered words (0..DEPTH)
// BEHAVIOUR
//  Reset (resetn=0 at posedge): pc=0, pending=0, FIFO empty, fifo_count=0, out_valid=0,
//   out_data=0, out_addr=0. rom_rden=0 while resetn=0.
//  Issue: rom_rden = resetn & ~redirect & (fifo_count + pending < DEPTH).
//   On an issue edge: pc <= pc+1 (wraps 2**AW-1 -> 0), pending <= 1, pend_addr <= pc.
//   No issue: pending <= 0, pc holds.
//  Capture: on an edge where pending=1 (and no redirect), rom_q/pend_addr are pushed into the FIFO.
//  Pop: on an edge where out_valid & out_ready, head advances.
//  Push and pop on the same edge: both occur; fifo_count unchanged.
//  Overflow is impossible: the credit check counts the in-flight word. A push while full is a
//   design error (assertion).
//  Pop while empty is ignored (out_ready with out_valid=0 has no effect).
//  Throughput: 1 word/cycle sustained while out_ready=1. With out_ready=0 the FIFO fills to DEPTH
//   and rom_rden stays low.
//  Latency: the first out_valid comes 2 edges after the first issue-enabled cycle.
//   E1 samples the address and issues. E2 captures the word. out_valid is high after E2.
//  Redirect (priority over everything except reset), on the edge: pc <= redirect_addr, FIFO cleared,
//   pending <= 0, so the in-flight rom_q is discarded. No pop is performed and no issue is made.
//   out_valid=0 in the next cycle. The target word is out_valid 2 edges later.
//  Consecutive redirects: only the last target is fetched. No stale word is ever presented.
//  Reset mid-stream: same as the reset state. The pending read is dropped.
//  out_data/out_addr hold their value while out_valid=1 & out_ready=0.
// TESTING
//  1. Reset, then out_ready=1, ROM[i]=i+8'h10 -> out_valid after 2 edges.
//     out_data 10,11,12,... one per cycle; out_addr 0,1,2,...
//  2. out_ready=0 from reset -> fifo_count reaches 4, rom_rden=0, pc=4.
//     out_data stays 10 until ready. Then ready=1 -> 10,11,12,13,14 with no gaps or duplicates.
//  3. Free run past address 31 -> out_addr ...,30,31,0,1; out_data wraps to ROM[0].
//  4. Redirect to 5'd20 while the FIFO holds 3 words and one read is pending.
//     -> out_valid=0 next cycle; the next word presented is ROM[20] with out_addr=20.
//     No pre-redirect word appears.
//  5. Toggle out_ready 1010... over 40 cycles -> output sequence in order; fifo_count never >4.
//     The scoreboard matches the ROM contents exactly.
//  6. resetn=0 for one cycle mid-stream with FIFO full -> fifo_count=0, out_valid=0.
//     The restart presents ROM[0] 2 edges after release.

Source files
------------

// File: rtl/instr_prefetch_unit.sv
// Instruction prefetch unit: walks a PC through a synchronous instruction ROM,
// buffers fetched words in a small FIFO and presents them with valid/ready.
// A redirect loads a new PC and discards every buffered and in-flight word.
module instr_prefetch_unit #(
    parameter int unsigned AW    = 5,
    parameter int unsigned DW    = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic          M_clock,
    input  logic          resetn,
    output logic [AW-1:0] rom_addr,
    output logic          rom_rden,
    input  logic [DW-1:0] rom_q,
    input  logic          redirect,
    input  logic [AW-1:0] redirect_addr,
    output logic [DW-1:0] out_data,
    output logic [AW-1:0] out_addr,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [2:0]    fifo_count
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0]  DepthW = 4'(DEPTH);

    logic [AW-1:0] pc_q, pc_d;
    logic          pending_q, pending_d;
    logic [AW-1:0] pend_addr_q, pend_addr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [2:0]    count_q, count_d;
    logic [DW-1:0] data_mem_q [DEPTH];
    logic [AW-1:0] addr_mem_q [DEPTH];

    logic       push;
    logic       pop;
    logic [3:0] credit_used;

    // Issue/capture/pop strobes; the credit check counts the in-flight word so the
    // FIFO can never overflow.
    always_comb begin
        credit_used = 4'(count_q) + 4'(pending_q);
        rom_rden    = resetn & ~redirect & (credit_used < DepthW);
        push        = pending_q & ~redirect;
        pop         = out_valid & out_ready & ~redirect;
    end

    assign rom_addr   = pc_q;
    assign out_valid  = (count_q != 3'd0);
    assign fifo_count = count_q;
    // Gate the head to zero when empty so no stale word is ever visible.
    assign out_data   = out_valid ? data_mem_q[rd_ptr_q] : '0;
    assign out_addr   = out_valid ? addr_mem_q[rd_ptr_q] : '0;

    // Next-state for PC, in-flight tracking and FIFO pointers; redirect wins.
    always_comb begin
        pc_d        = pc_q;
        pending_d   = rom_rden;
        pend_addr_d = pend_addr_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        if (redirect) begin
            pc_d      = redirect_addr;
            pending_d = 1'b0;
            wr_ptr_d  = '0;
            rd_ptr_d  = '0;
            count_d   = 3'd0;
        end else begin
            if (rom_rden) begin
                pc_d        = pc_q + AW'(1);
                pend_addr_d = pc_q;
            end
            if (push) wr_ptr_d = wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
            unique case ({push, pop})
                2'b10:   count_d = count_q + 3'd1;
                2'b01:   count_d = count_q - 3'd1;
                default: count_d = count_q;
            endcase
        end
    end

    // Control state register with synchronous active-low reset.
    always_ff @(posedge M_clock) begin
        if (!resetn) begin
            pc_q        <= '0;
            pending_q   <= 1'b0;
            pend_addr_q <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= 3'd0;
        end else begin
            pc_q        <= pc_d;
            pending_q   <= pending_d;
            pend_addr_q <= pend_addr_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
        end
    end

    // FIFO storage: capture the word returned for the previously issued address.
    always_ff @(posedge M_clock) begin
        if (resetn && push) begin
            data_mem_q[wr_ptr_q] <= rom_q;
            addr_mem_q[wr_ptr_q] <= pend_addr_q;
        end
    end

    // A capture into a full FIFO means the credit accounting is broken.
    push_not_full_a: assert property (@(posedge M_clock) disable iff (!resetn)
        !(push && (count_q == 3'(DEPTH))));

endmodule

// File: tb/tb_instr_prefetch_unit.sv
// Directed self-checking bench for instr_prefetch_unit with a 32x8 synchronous
// ROM model holding ROM[i] = i + 8'h10.
module tb_instr_prefetch_unit;

    logic       M_clock;
    logic       resetn;
    logic [4:0] rom_addr;
    logic       rom_rden;
    logic [7:0] rom_q;
    logic       redirect;
    logic [4:0] redirect_addr;
    logic [7:0] out_data;
    logic [4:0] out_addr;
    logic       out_valid;
    logic       out_ready;
    logic [2:0] fifo_count;

    logic [7:0] rom_mem [32];
    int checks;
    int failures;
    int exp_idx;

    instr_prefetch_unit #(.AW(5), .DW(8), .DEPTH(4)) dut (
        .M_clock      (M_clock),
        .resetn       (resetn),
        .rom_addr     (rom_addr),
        .rom_rden     (rom_rden),
        .rom_q        (rom_q),
        .redirect     (redirect),
        .redirect_addr(redirect_addr),
        .out_data     (out_data),
        .out_addr     (out_addr),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .fifo_count   (fifo_count)
    );

    initial M_clock = 1'b0;
    always #5 M_clock = ~M_clock;

    // Synchronous ROM: data for the sampled address appears after the edge.
    initial begin
        for (int i = 0; i < 32; i++) rom_mem[i] = 8'(i + 16);
        rom_q = 8'h00;
    end
    always @(posedge M_clock) rom_q <= rom_mem[rom_addr];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance n clock cycles; returns at a falling edge (sample/drive point).
    task automatic step(input int n);
        repeat (n) @(negedge M_clock);
    endtask

    initial begin
        checks = 0;
        failures = 0;
        resetn = 1'b0;
        out_ready = 1'b0;
        redirect = 1'b0;
        redirect_addr = 5'd0;
        step(2);

        // Reset state
        chk("rst_rden", rom_rden, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_count", fifo_count, 0);
        chk("rst_data", out_data, 0);
        chk("rst_addr", out_addr, 0);

        // Free-run stream with wrap past address 31
        resetn = 1'b1;
        out_ready = 1'b1;
        step(1);
        chk("t1_lat_valid", out_valid, 0);
        step(1);
        for (int k = 0; k < 40; k++) begin
            chk("t1_valid", out_valid, 1);
            chk("t1_data", out_data, 32'(8'(16 + (k % 32))));
            chk("t1_addr", out_addr, 32'(k % 32));
            step(1);
        end

        // Back-pressure from reset: FIFO fills, fetch stalls, then drains in order
        resetn = 1'b0;
        out_ready = 1'b0;
        step(1);
        chk("t2_rst_count", fifo_count, 0);
        chk("t2_rst_valid", out_valid, 0);
        resetn = 1'b1;
        step(6);
        chk("t2_full_count", fifo_count, 4);
        chk("t2_full_rden", rom_rden, 0);
        chk("t2_full_pc", rom_addr, 4);
        chk("t2_hold_data", out_data, 8'h10);
        step(2);
        chk("t2_hold_data2", out_data, 8'h10);
        chk("t2_hold_addr2", out_addr, 0);
        out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            chk("t2_valid", out_valid, 1);
            chk("t2_data", out_data, 32'(8'(16 + k)));
            step(1);
        end

        // Redirect with 3 buffered words and one read in flight
        resetn = 1'b0;
        out_ready = 1'b0;
        step(1);
        resetn = 1'b1;
        step(4);
        chk("t4_pre_count", fifo_count, 3);
        redirect = 1'b1;
        redirect_addr = 5'd20;
        #1;
        chk("t4_redir_rden", rom_rden, 0);
        step(1);
        redirect = 1'b0;
        out_ready = 1'b1;
        chk("t4_post_valid", out_valid, 0);
        chk("t4_post_count", fifo_count, 0);
        chk("t4_post_pc", rom_addr, 20);
        step(1);
        chk("t4_lat_valid", out_valid, 0);
        step(1);
        for (int k = 0; k < 3; k++) begin
            chk("t4_valid", out_valid, 1);
            chk("t4_data", out_data, 32'(8'(16 + 20 + k)));
            chk("t4_addr", out_addr, 32'(20 + k));
            step(1);
        end

        // Back-to-back redirects: only the last target is fetched
        redirect = 1'b1;
        redirect_addr = 5'd7;
        step(1);
        redirect_addr = 5'd9;
        step(1);
        redirect = 1'b0;
        chk("t4b_valid0", out_valid, 0);
        step(1);
        chk("t4b_valid1", out_valid, 0);
        step(1);
        chk("t4b_valid", out_valid, 1);
        chk("t4b_data", out_data, 8'h19);
        chk("t4b_addr", out_addr, 9);

        // Alternating ready with an in-order scoreboard
        resetn = 1'b0;
        out_ready = 1'b0;
        step(1);
        resetn = 1'b1;
        exp_idx = 0;
        for (int i = 0; i < 40; i++) begin
            out_ready = (i % 2 == 0);
            if (out_valid && out_ready) begin
                chk("t5_data", out_data, 32'(8'(16 + (exp_idx % 32))));
                chk("t5_addr", out_addr, 32'(exp_idx % 32));
                exp_idx++;
            end
            chk("t5_count_le4", 32'(fifo_count <= 3'd4), 1);
            step(1);
        end
        chk("t5_pops", exp_idx, 19);

        // Reset mid-stream with a full FIFO
        out_ready = 1'b0;
        step(6);
        chk("t6_full_count", fifo_count, 4);
        resetn = 1'b0;
        #1;
        chk("t6_rst_rden", rom_rden, 0);
        step(1);
        chk("t6_rst_count", fifo_count, 0);
        chk("t6_rst_valid", out_valid, 0);
        chk("t6_rst_data", out_data, 0);
        resetn = 1'b1;
        out_ready = 1'b1;
        step(1);
        chk("t6_lat_valid", out_valid, 0);
        step(1);
        chk("t6_valid", out_valid, 1);
        chk("t6_data", out_data, 8'h10);
        chk("t6_addr", out_addr, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
